// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters.
// Optional illegal-op check enabled by defining ALU_ARB_OPCHK_EN.
module alu_share_arbiter #(
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [7:0]          req_op,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_zero,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   alu_rd1,
    output logic [DATA_W-1:0]   alu_rd2,
    output logic [3:0]          alu_op,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                alu_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                grant_id_r;
    logic                last_grant_r;
    logic                sel_s;
    logic                accept_s;
    logic                grant_next_s;
    logic [3:0]          sel_op_s;
    logic [DATA_W-1:0]   sel_a_s;
    logic [DATA_W-1:0]   sel_b_s;

`ifdef ALU_ARB_OPCHK_EN
    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction
`endif

    // Requester selection, ready decode and next-state logic
    always_comb begin
        sel_s        = 1'b0;
        req_ready    = 2'b00;
        state_s      = state_r;
        case (req_valid)
            2'b01:   sel_s = 1'b0;
            2'b10:   sel_s = 1'b1;
            2'b11:   sel_s = ~last_grant_r;
            default: sel_s = 1'b0;
        endcase
        if ((state_r == IDLE) && (req_valid != 2'b00)) begin
            req_ready = sel_s ? 2'b10 : 2'b01;
        end else begin
            req_ready = 2'b00;
        end
        accept_s     = |(req_valid & req_ready);
        grant_next_s = accept_s ? sel_s : grant_id_r;
        sel_op_s     = sel_s ? req_op[7:4] : req_op[3:0];
        sel_a_s      = sel_s ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
        sel_b_s      = sel_s ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
        case (state_r)
            IDLE: begin
                if (accept_s) begin
`ifdef ALU_ARB_OPCHK_EN
                    // Illegal ops skip the ALU and answer straight away
                    state_s = op_is_legal(sel_op_s) ? EXEC : RESP;
`else
                    state_s = EXEC;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC:    state_s = CAPT;
            CAPT:    state_s = RESP;
            RESP: begin
                if (rsp_ready[grant_id_r]) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, grant tracking, ALU operand and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            grant_id_r   <= 1'b0;
            last_grant_r <= 1'b1;
            rsp_valid    <= 2'b00;
            rsp_data     <= '0;
            rsp_zero     <= 1'b0;
            alu_rd1      <= '0;
            alu_rd2      <= '0;
            alu_op       <= 4'b0010;
`ifdef ALU_ARB_OPCHK_EN
            rsp_err      <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            rsp_valid <= (state_s == RESP) ? {grant_next_s, ~grant_next_s} : 2'b00;
            if (accept_s) begin
                grant_id_r   <= sel_s;
                last_grant_r <= sel_s;
`ifdef ALU_ARB_OPCHK_EN
                if (op_is_legal(sel_op_s)) begin
                    alu_rd1 <= sel_a_s;
                    alu_rd2 <= sel_b_s;
                    alu_op  <= sel_op_s;
                end else begin
                    rsp_data <= '0;
                    rsp_zero <= 1'b0;
                    rsp_err  <= 1'b1;
                end
`else
                alu_rd1 <= sel_a_s;
                alu_rd2 <= sel_b_s;
                alu_op  <= sel_op_s;
`endif
            end
            if (state_r == CAPT) begin
                rsp_data <= alu_result;
                rsp_zero <= alu_zero;
`ifdef ALU_ARB_OPCHK_EN
                rsp_err  <= 1'b0;
`endif
            end
        end
    end

`ifndef ALU_ARB_OPCHK_EN
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized bench for alu_share_arbiter with a transaction-level reference model
// and a stand-in registered ALU; honours ALU_ARB_OPCHK_EN when defined.
module tb_alu_share_arbiter;
    localparam int W = 64;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [7:0]     req_op;
    logic [2*W-1:0] req_a, req_b;
    logic [W-1:0]   rsp_data, alu_rd1, alu_rd2;
    logic [W-1:0]   alu_result = '0;
    logic           alu_zero = 1'b1;
    logic           rsp_zero, rsp_err;
    logic [3:0]     alu_op;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_rd1(alu_rd1), .alu_rd2(alu_rd2), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [W-1:0] prev);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            default: return prev;
        endcase
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return (op == 4'h0) || (op == 4'h1) || (op == 4'h2) || (op == 4'h6);
    endfunction

    // Stand-in registered ALU: result and Zero update every clock, unlisted ops hold
    always @(posedge clk) begin
        alu_result <= alu_fn(alu_op, alu_rd1, alu_rd2, alu_result);
        alu_zero   <= (alu_fn(alu_op, alu_rd1, alu_rd2, alu_result) == '0);
    end

    // Reference model: owner of the in-flight op and edges elapsed since accept
    int           m_owner = -1;
    int           m_cnt   = 0;
    int           m_last  = 1;
    logic         m_init  = 1'b0;
    logic [W-1:0] m_data, m_prev, m_rd1, m_rd2;
    logic [3:0]   m_op;
    logic         m_zero, m_err;
    logic [1:0]   obs_ready;

    function automatic int pick(input logic [1:0] v);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        return (m_last == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [1:0] v, input logic [3:0] op0,
                              input logic [3:0] op1, input logic [W-1:0] a0, input logic [W-1:0] b0,
                              input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [1:0] rr);
        int           c;
        logic [3:0]   o;
        logic [W-1:0] a, b, res;
        if (!r) begin
            m_owner = -1; m_cnt = 0; m_last = 1; m_init = 1'b1;
            m_rd1 = '0; m_rd2 = '0; m_op = 4'b0010; m_prev = '0;
            m_data = '0; m_zero = 1'b0; m_err = 1'b0;
        end else if (m_owner < 0) begin
            if (v != 2'b00) begin
                c = pick(v);
                o = (c == 1) ? op1 : op0;
                a = (c == 1) ? a1 : a0;
                b = (c == 1) ? b1 : b0;
                m_owner = c; m_last = c;
`ifdef ALU_ARB_OPCHK_EN
                if (!is_legal(o)) begin
                    m_cnt = 2; m_data = '0; m_zero = 1'b0; m_err = 1'b1;
                end else begin
`else
                begin
`endif
                    res = is_legal(o) ? alu_fn(o, a, b, m_prev) : m_prev;
                    m_cnt = 0; m_op = o; m_rd1 = a; m_rd2 = b; m_prev = res;
                    m_data = res; m_zero = (res == '0); m_err = 1'b0;
                end
            end
        end else if (m_cnt >= 2) begin
            if (rr[m_owner]) m_owner = -1;
        end else begin
            m_cnt++;
        end
    endtask

    // One clock: drive at negedge, compare, then advance the model over the posedge
    task automatic cyc(input logic r, input logic [1:0] v, input logic [3:0] op0, input logic [3:0] op1,
                       input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [W-1:0] a1,
                       input logic [W-1:0] b1, input logic [1:0] rr);
        logic [1:0] exp_ready, exp_valid;
        rst_n = r; req_valid = v; req_op = {op1, op0};
        req_a = {a1, a0}; req_b = {b1, b0}; rsp_ready = rr;
        #1;
        obs_ready = req_ready;
        if (m_init) begin
            exp_ready = 2'b00;
            if (m_owner < 0 && v != 2'b00) exp_ready = (pick(v) == 1) ? 2'b10 : 2'b01;
            exp_valid = 2'b00;
            if (m_owner >= 0 && m_cnt >= 2) exp_valid = (m_owner == 1) ? 2'b10 : 2'b01;
            chk("req_ready", W'(req_ready), W'(exp_ready));
            chk("rsp_valid", W'(rsp_valid), W'(exp_valid));
            chk("alu_op", W'(alu_op), W'(m_op));
            chk("alu_rd1", alu_rd1, m_rd1);
            chk("alu_rd2", alu_rd2, m_rd2);
            if (exp_valid != 2'b00) begin
                chk("rsp_data", rsp_data, m_data);
                chk("rsp_zero", W'(rsp_zero), W'(m_zero));
                chk("rsp_err", W'(rsp_err), W'(m_err));
            end
        end
        @(posedge clk);
        model_step(r, v, op0, op1, a0, b0, a1, b1, rr);
        @(negedge clk);
    endtask

    task automatic idle_cyc(input logic [1:0] rr);
        cyc(1'b1, 2'b00, 4'h2, 4'h2, '0, '0, '0, '0, rr);
    endtask

    logic [1:0]   order [$];
    logic [W-1:0] seen_or;
    logic         seen_zero;
    logic [3:0]   prev_op;
    logic [3:0]   legal_ops [4] = '{4'h0, 4'h1, 4'h2, 4'h6};

    initial begin
        @(negedge clk);
        cyc(1'b0, 2'b00, 4'h0, 4'h0, '0, '0, '0, '0, 2'b00);
        cyc(1'b0, 2'b00, 4'h0, 4'h0, '0, '0, '0, '0, 2'b00);
        chk("reset_rsp_valid", W'(rsp_valid), W'(2'b00));
        chk("reset_rsp_data", rsp_data, 64'd0);
        chk("reset_alu_op", W'(alu_op), W'(4'b0010));

        // req0 ADD 5+7, then the response held for 5 cycles
        cyc(1'b1, 2'b01, 4'h2, 4'h0, 64'd5, 64'd7, '0, '0, 2'b00);
        chk("add_ready", W'(obs_ready), W'(2'b01));
        idle_cyc(2'b00);
        chk("add_not_yet", W'(rsp_valid), W'(2'b00));
        idle_cyc(2'b00);
        chk("add_valid", W'(rsp_valid), W'(2'b01));
        chk("add_data", rsp_data, 64'd12);
        chk("add_zero", W'(rsp_zero), W'(1'b0));
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 2'b11, 4'h1, 4'h1, 64'd1, 64'd2, 64'd3, 64'd4, 2'b10);
            chk("hold_ready", W'(obs_ready), W'(2'b00));
            chk("hold_data", rsp_data, 64'd12);
            chk("hold_rd1", alu_rd1, 64'd5);
        end
        idle_cyc(2'b01);

        // Reset while in CAPT aborts the operation
        cyc(1'b1, 2'b01, 4'h2, 4'h0, 64'd1, 64'd1, '0, '0, 2'b00);
        idle_cyc(2'b00);
        cyc(1'b0, 2'b00, 4'h0, 4'h0, '0, '0, '0, '0, 2'b11);
        chk("abort_valid", W'(rsp_valid), W'(2'b00));
        chk("abort_data", rsp_data, 64'd0);
        chk("abort_rd1", alu_rd1, 64'd0);
        chk("abort_op", W'(alu_op), W'(4'b0010));

        // Both requesters always valid: round-robin starting at requester 0
        seen_or = '0; seen_zero = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 2'b11, 4'h6, 4'h1, 64'd9, 64'd9, 64'hF0, 64'h0F, 2'b11);
            if (obs_ready != 2'b00) order.push_back(obs_ready);
            if (rsp_valid == 2'b10) seen_or = rsp_data;
            if (rsp_valid == 2'b01) seen_zero = rsp_zero;
        end
        chk("rr_count", W'(order.size()), W'(3));
        chk("rr_first", W'(order[0]), W'(2'b01));
        chk("rr_second", W'(order[1]), W'(2'b10));
        chk("rr_third", W'(order[2]), W'(2'b01));
        chk("or_data", seen_or, 64'hFF);
        chk("sub_zero", W'(seen_zero), W'(1'b1));
        for (int i = 0; i < 4; i++) idle_cyc(2'b11);

        // Wrap-around add on requester 1
        cyc(1'b1, 2'b10, 4'h0, 4'h2, '0, '0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00);
        chk("wrap_ready", W'(obs_ready), W'(2'b10));
        idle_cyc(2'b01);
        idle_cyc(2'b01);
        chk("wrap_valid", W'(rsp_valid), W'(2'b10));
        chk("wrap_data", rsp_data, 64'd0);
        chk("wrap_zero", W'(rsp_zero), W'(1'b1));
        idle_cyc(2'b10);

`ifdef ALU_ARB_OPCHK_EN
        prev_op = alu_op;
        cyc(1'b1, 2'b01, 4'h5, 4'h0, 64'd3, 64'd4, '0, '0, 2'b00);
        chk("opchk_valid", W'(rsp_valid), W'(2'b01));
        chk("opchk_err", W'(rsp_err), W'(1'b1));
        chk("opchk_data", rsp_data, 64'd0);
        chk("opchk_alu_op", W'(alu_op), W'(prev_op));
        idle_cyc(2'b01);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            logic [3:0]   o0, o1;
            logic [W-1:0] ra0, rb0, ra1, rb1;
            o0  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : legal_ops[$urandom_range(0, 3)];
            o1  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : legal_ops[$urandom_range(0, 3)];
            ra0 = {$urandom(), $urandom()};
            ra1 = {$urandom(), $urandom()};
            rb0 = ($urandom_range(0, 3) == 0) ? ra0 : {$urandom(), $urandom()};
            rb1 = ($urandom_range(0, 3) == 0) ? ra1 : {$urandom(), $urandom()};
            cyc(($urandom_range(0, 99) != 0), 2'($urandom_range(0, 3)), o0, o1,
                ra0, rb0, ra1, rb1, 2'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
